// File: rtl/message_schedule_if.sv
// Handshake and data bundle for message_schedule: message words in, schedule words out.
interface message_schedule_if;
    logic        start;
    logic [31:0] msg_word;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] w_word;
    logic [5:0]  w_index;
    logic        w_valid;
    logic        w_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, msg_word, msg_valid, w_ready,
        input  msg_ready, w_word, w_index, w_valid, busy, done
    );

    modport slave (
        input  start, msg_word, msg_valid, w_ready,
        output msg_ready, w_word, w_index, w_valid, busy, done
    );
endinterface

// File: rtl/message_schedule.sv
// SHA-256 message schedule: 16 loaded words expanded to W0..W63; optional abort input under MESSAGE_SCHEDULE_ABORT_EN.
// Latency: 1 cycle from an accepted message word or free output slot to w_word; one word per cycle.
// Backpressure: w_valid && !w_ready freezes the output and the window; msg_ready drops until the slot frees.
module message_schedule (
    input  logic clk,
    input  logic rst,
`ifdef MESSAGE_SCHEDULE_ABORT_EN
    input  logic abort,
`endif
    message_schedule_if.slave ms
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  t;
    logic [31:0] win [16];
    logic [31:0] w_word_q;
    logic [5:0]  w_index_q;
    logic        w_valid_q;
    logic        slot_free;
    logic        accept;
    logic        produce;
    logic        last_xfer;
    logic        abort_req;
    logic [31:0] next_w;

`ifdef MESSAGE_SCHEDULE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign slot_free = !w_valid_q || ms.w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        produce   = 1'b0;
        last_xfer = 1'b0;
        case (state)
            IDLE: begin
                if (ms.start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                accept = ms.msg_valid && slot_free;
                if (accept && t == 6'd15) begin
                    state_nx = EXPAND;
                end
            end
            EXPAND: begin
                // W63 on the output: wait for its transfer, never expand past it
                if (w_valid_q && w_index_q == 6'd63) begin
                    if (ms.w_ready) begin
                        last_xfer = 1'b1;
                        state_nx  = IDLE;
                    end
                end else if (slot_free) begin
                    produce = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort_req) begin
            state_nx  = IDLE;
            accept    = 1'b0;
            produce   = 1'b0;
            last_xfer = 1'b0;
        end
    end

    // win[15] is W[t-1], win[0] is W[t-16]
    always_comb begin
        next_w = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
        if (accept) begin
            next_w = ms.msg_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t         <= 6'd0;
            w_word_q  <= 32'd0;
            w_index_q <= 6'd0;
            w_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else if (abort_req) begin
            t         <= 6'd0;
            w_valid_q <= 1'b0;
        end else begin
            if (state == IDLE && ms.start) begin
                t <= 6'd0;
            end
            if (accept || produce) begin
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i+1];
                end
                win[15]   <= next_w;
                w_word_q  <= next_w;
                w_index_q <= t;
                w_valid_q <= 1'b1;
                if (t != 6'd63) begin
                    t <= t + 6'd1;
                end
            end else if (ms.w_ready) begin
                w_valid_q <= 1'b0;
            end
        end
    end

    assign ms.msg_ready = (state == LOAD) && slot_free;
    assign ms.w_word    = w_word_q;
    assign ms.w_index   = w_index_q;
    assign ms.w_valid   = w_valid_q;
    assign ms.busy      = (state != IDLE);
    assign ms.done      = last_xfer;
endmodule

// File: tb/tb_message_schedule.sv
// Scoreboard bench for message_schedule: directed blocks with hand-computed schedule words.
module tb_message_schedule;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef MESSAGE_SCHEDULE_ABORT_EN
    logic abort = 1'b0;
`endif

    always #5 clk = ~clk;

    message_schedule_if ms();

    message_schedule dut (
        .clk  (clk),
        .rst  (rst),
`ifdef MESSAGE_SCHEDULE_ABORT_EN
        .abort(abort),
`endif
        .ms   (ms)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] word;
        bit          known;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    logic [31:0] exp_w [64];
    bit          exp_known [64];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output transfer pops one expected entry
    always @(negedge clk) begin
        if (mon_en) begin
            if (ms.w_valid === 1'b1 && ms.w_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got index %0d, want no transfer", ms.w_index);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("w_index", {26'd0, ms.w_index}, {26'd0, mon_e.idx});
                    if (mon_e.known) begin
                        chk("w_word", ms.w_word, mon_e.word);
                    end
                    chk("done_on_xfer", {31'd0, ms.done}, {31'd0, (mon_e.idx == 6'd63)});
                end
            end else if (ms.done === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL stray_done: got done=1 without W63 transfer, want 0");
            end
        end
    end

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) begin
            exp_w[i]     = 32'd0;
            exp_known[i] = 1'b0;
        end
    endtask

    task automatic load_abc();
        clear_exp();
        exp_w[0]  = 32'h61626380;
        exp_w[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) exp_known[i] = 1'b1;
        exp_w[16] = 32'h61626380; exp_known[16] = 1'b1;
        exp_w[17] = 32'h000F0000; exp_known[17] = 1'b1;
        exp_w[18] = 32'h7DA86405; exp_known[18] = 1'b1;
        exp_w[19] = 32'h600003C6; exp_known[19] = 1'b1;
        exp_w[20] = 32'h3E9D7B78; exp_known[20] = 1'b1;
        exp_w[63] = 32'h12B1EDEB; exp_known[63] = 1'b1;
    endtask

    task automatic load_zero();
        clear_exp();
        for (int i = 0; i < 64; i++) exp_known[i] = 1'b1;
    endtask

    // Starts a block and runs until n words have been transferred.
    // stall_t: hold w_ready low 3 cycles when that index is shown; start_t: pulse start there.
    task automatic run_block(input int n, input int stall_t, input int start_t);
        int   sent = 0;
        int   xfer = 0;
        int   stall_left = 3;
        int   cyc = 0;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx   = i[5:0];
            e.word  = exp_w[i];
            e.known = exp_known[i];
            sb_q.push_back(e);
        end
        ms.w_ready = 1'b1;
        ms.start   = 1'b1;
        @(posedge clk); #1;
        ms.start = 1'b0;
        chk("busy_after_start", {31'd0, ms.busy}, 32'd1);
        while (xfer < n && cyc < 1000) begin
            if (sent < 16) begin
                ms.msg_valid = 1'b1;
                ms.msg_word  = exp_w[sent];
            end else begin
                ms.msg_valid = 1'b0;
                ms.msg_word  = 32'd0;
            end
            ms.w_ready = 1'b1;
            if (stall_t >= 0 && stall_left > 0 && ms.w_valid === 1'b1 && ms.w_index == stall_t[5:0]) begin
                ms.w_ready = 1'b0;
                stall_left--;
                chk("stall_word_frozen", ms.w_word, exp_w[stall_t]);
            end
            ms.start = (start_t >= 0 && ms.w_valid === 1'b1 && ms.w_index == start_t[5:0]);
            @(negedge clk);
            if (ms.msg_valid && ms.msg_ready) sent++;
            if (ms.w_valid && ms.w_ready) xfer++;
            @(posedge clk); #1;
            cyc++;
        end
        ms.start     = 1'b0;
        ms.msg_valid = 1'b0;
        chk("xfer_count", xfer, n);
        if (stall_t >= 0) chk("stall_cycles_used", stall_left, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, ms.busy}, 32'd0);
        chk({tag, "_w_valid"}, {31'd0, ms.w_valid}, 32'd0);
        chk({tag, "_done"}, {31'd0, ms.done}, 32'd0);
        chk({tag, "_queue_empty"}, sb_q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, {31'd0, ms.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, ms.done}, 32'd0);
        chk({tag, "_w_valid"}, {31'd0, ms.w_valid}, 32'd0);
        chk({tag, "_msg_ready"}, {31'd0, ms.msg_ready}, 32'd0);
        chk({tag, "_w_index"}, {26'd0, ms.w_index}, 32'd0);
        chk({tag, "_w_word"}, ms.w_word, 32'd0);
    endtask

    initial begin
        ms.start     = 1'b0;
        ms.msg_valid = 1'b0;
        ms.msg_word  = 32'd0;
        ms.w_ready   = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        // IDLE must not accept words
        ms.msg_valid = 1'b1;
        ms.w_ready   = 1'b1;
        @(posedge clk); #1;
        chk("idle_msg_ready", {31'd0, ms.msg_ready}, 32'd0);
        ms.msg_valid = 1'b0;

        load_abc();
        run_block(64, -1, -1);
        check_idle("abc_end");

        load_zero();
        run_block(64, -1, 63);
        check_idle("zero_start_at_last");

        load_abc();
        run_block(64, 20, -1);
        check_idle("abc_stall");

        load_abc();
        run_block(64, -1, 30);
        check_idle("abc_start_busy");

        // Reset at t=40 with start held; block is discarded
        load_abc();
        run_block(40, -1, -1);
        ms.w_ready = 1'b0;
        ms.start   = 1'b1;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        ms.start = 1'b0;
        check_reset_state("midrun_reset");
        chk("midrun_reset_queue", sb_q.size(), 32'd0);
        load_abc();
        run_block(64, -1, -1);
        check_idle("abc_after_reset");

`ifdef MESSAGE_SCHEDULE_ABORT_EN
        load_abc();
        run_block(10, -1, -1);
        ms.w_ready = 1'b0;
        ms.start   = 1'b1;
        abort      = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        ms.start = 1'b0;
        check_idle("abort");
        load_abc();
        run_block(64, -1, -1);
        check_idle("abc_after_abort");
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/message_schedule.md
MESSAGE_SCHEDULE -- requirements
Module: message_schedule

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  begin a new 512-bit block schedule.
REQ-004 SHALL have ports msg_word  input  32 and msg_valid  input  1: the block's message words, W0 first.
REQ-005 SHALL have port: msg_ready  output  1  word accepted on msg_valid && msg_ready.
REQ-006 SHALL have ports w_word  output  32 and w_index  output  6: current schedule word W[t] and its index t.
REQ-007 SHALL have ports w_valid  output  1 and w_ready  input  1: word transferred on w_valid && w_ready.
REQ-008 SHALL have ports busy  output  1 (state != IDLE) and done  output  1 (one-cycle pulse).

Function
REQ-009 SHALL implement states IDLE, LOAD, EXPAND; t counter 0..63; 16x32 window holding W[t-16..t-1].
REQ-010 IDLE: msg_ready=0, w_valid=0; start -> LOAD, t=0; start while busy SHALL be ignored.
REQ-011 Output slot free = !w_valid || w_ready; msg_ready SHALL equal (state==LOAD) && slot free.
REQ-012 LOAD: accepted word shifts into window and appears on w_word with w_index=t, w_valid=1, next cycle (latency 1).
REQ-013 After the 16th accept (t=15), state SHALL go to EXPAND.
REQ-014 EXPAND: when slot free, SHALL produce W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^32, shift it in, present next cycle.
REQ-015 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10; rotations are right cyclic over 32 bits.
REQ-016 Throughput: one word per cycle with w_ready held high; W15 -> W16 has no bubble.
REQ-017 While w_valid && !w_ready, w_word, w_index, w_valid SHALL hold stable; the window SHALL NOT advance.
REQ-018 When W63 is transferred, done SHALL pulse exactly one cycle and state SHALL return to IDLE; a start in that same cycle SHALL be ignored.
REQ-019 w_index SHALL never wrap; no word beyond t=63 SHALL be produced.

Reset
REQ-020 rst SHALL force IDLE, t=0, window=0, w_word=0, w_index=0, w_valid=0, msg_ready=0, busy=0, done=0 on the next clk edge.
REQ-021 rst asserted mid-LOAD or mid-EXPAND SHALL discard the block with no done pulse; rst SHALL take priority over start.

Configuration
REQ-022 Macro MESSAGE_SCHEDULE_ABORT_EN: when defined, SHALL add input abort (1 bit).
REQ-023 abort=1 in any state SHALL return to IDLE next cycle, clear w_valid, with no done pulse. The window is left unspecified, and start in that cycle is ignored.
REQ-024 Without MESSAGE_SCHEDULE_ABORT_EN, the abort port SHALL be absent; behaviour is otherwise identical.

Verification
REQ-025 Input "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, w_ready=1 -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, done on the W63 transfer cycle.
REQ-026 All-zero block -> 64 words, all 0x00000000, w_index 0..63 in order, exactly one done pulse.
REQ-027 "abc" block with w_ready low for 3 cycles at t=20 -> w_word/w_index frozen at t=20; resumed stream identical to REQ-025.
REQ-028 rst asserted at t=40, then a new start with the "abc" block -> no done from the first block; second run matches REQ-025.
REQ-029 start pulsed at t=30 -> ignored; output sequence unchanged.
REQ-030 With MESSAGE_SCHEDULE_ABORT_EN, abort at t=10 -> busy=0 and w_valid=0 next cycle, no done; a following start runs a clean schedule.
